// File: rtl/coincidence_window_counter.sv
`default_nettype none
// ============================================================================
// Module  : coincidence_window_counter
// Brief   : Counts rising edges of (a & b) over a fixed window and reports
//           each window result on a valid/ready port.
//           Macro COINC_CNT_SATURATE_EN: saturate accumulator (default wraps).
// Revision: 1.0  initial release
// ============================================================================
module coincidence_window_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int                WIN_W      = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]  c_win_last = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  c_acc_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_w_q;
  logic [CNT_W-1:0]   r_acc;
  logic               r_ovf;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_coinc;
  logic               w_edge;
  logic               w_last;
  logic               w_handshake;
  logic               w_start;
  logic               w_acc_inc;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_acc_next;

  assign w_coinc     = a & b;
  assign w_edge      = w_coinc & ~r_w_q;
  assign w_last      = (r_win_cnt == c_win_last);
  assign w_handshake = (r_state == S_REPORT) & out_ready;
  // A window starts from IDLE or straight out of a report handshake.
  assign w_start     = en & ((r_state == S_IDLE) | w_handshake);
  assign w_acc_inc   = w_edge & (r_state == S_COUNT);
  assign w_wrap      = w_acc_inc & (r_acc == c_acc_max);

`ifdef COINC_CNT_SATURATE_EN
  assign w_acc_next  = w_wrap ? r_acc : r_acc + CNT_W'(w_acc_inc);
`else
  assign w_acc_next  = r_acc + CNT_W'(w_acc_inc);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_last) w_state_next = S_REPORT;
      end
      S_REPORT: begin
        if (out_ready) w_state_next = en ? S_COUNT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_q       <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_win_cnt   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_w_q <= w_coinc;
      if (w_start) begin
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        r_win_cnt <= '0;
      end else if (r_state == S_COUNT) begin
        r_acc     <= w_acc_next;
        r_ovf     <= r_ovf | w_wrap;
        r_win_cnt <= r_win_cnt + WIN_W'(1);
        // Result includes the edge seen in the final window cycle.
        if (w_last) begin
          r_out_count <= w_acc_next;
          r_out_ovf   <= r_ovf | w_wrap;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_REPORT);
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_coincidence_window_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_coincidence_window_counter
// Brief   : Directed + randomized bench; expected window results come from a
//           per-cycle history of (a & b) and plain edge-counting arithmetic.
// Revision: 1.0  initial release
// ============================================================================
module tb_coincidence_window_counter;

  localparam int WIN     = 16;
  localparam int W_MAIN  = 8;
  localparam int W_SMALL = 2;

  logic clk = 1'b0;
  logic rst, a, b, en, out_ready;

  logic              busy_m, valid_m, ovf_m;
  logic [W_MAIN-1:0] cnt_m;
  logic              busy_s, valid_s, ovf_s;
  logic [W_SMALL-1:0] cnt_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_n    = 0;
  bit hist [0:8191];

  coincidence_window_counter #(.CNT_W(W_MAIN), .WINDOW(WIN)) u_dut_main (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .busy(busy_m),
    .out_valid(valid_m), .out_ready(out_ready), .out_count(cnt_m), .out_ovf(ovf_m)
  );

  coincidence_window_counter #(.CNT_W(W_SMALL), .WINDOW(WIN)) u_dut_small (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .busy(busy_s),
    .out_valid(valid_s), .out_ready(out_ready), .out_count(cnt_s), .out_ovf(ovf_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs held for the cycle, outputs sampled 1 unit after the edge.
  task automatic drive(input logic ia, input logic ib, input logic ien, input logic ird);
    a = ia; b = ib; en = ien; out_ready = ird;
    hist[cyc] = ia & ib;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Input pattern for window-relative cycle i (i = -1 is the start-request cycle).
  function automatic logic [1:0] pat(input int mode, input int i);
    logic [1:0] r;
    case (mode)
      1: r = {1'b1, (i >= 0) && ((i % 4) >= 2)};
      2: r = {1'b0, i[0]};
      3: r = {1'b1, (i >= 0) && i[0]};
      4: r = 2'b11;
      5: r = {1'b1, i == WIN - 1};
      default: r = {($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))};
    endcase
    return r;
  endfunction

  function automatic int edges_from(input int s);
    int n;
    n = 0;
    for (int k = s; k < s + WIN; k++)
      if (hist[k] && !hist[k-1]) n++;
    return n;
  endfunction

  function automatic int exp_count(input int n, input int w);
    int m;
    m = (1 << w) - 1;
`ifdef COINC_CNT_SATURATE_EN
    return (n > m) ? m : n;
`else
    return n % (1 << w);
`endif
  endfunction

  task automatic chk_result(input string tag);
    chk({tag, "_valid_m"}, valid_m, 1);
    chk({tag, "_valid_s"}, valid_s, 1);
    chk({tag, "_busy_m"},  busy_m, 1);
    chk({tag, "_cnt_m"},   cnt_m, exp_count(exp_n, W_MAIN));
    chk({tag, "_ovf_m"},   ovf_m, exp_n > 255);
    chk({tag, "_cnt_s"},   cnt_s, exp_count(exp_n, W_SMALL));
    chk({tag, "_ovf_s"},   ovf_s, exp_n > 3);
  endtask

  // first=1: request the window from IDLE; otherwise the previous handshake did.
  task automatic do_window(input int mode, input bit first, input string tag);
    int s;
    logic [1:0] ab;
    if (first) begin
      chk({tag, "_idle_busy"}, busy_m, 0);
      ab = pat(mode, -1);
      drive(ab[1], ab[0], 1'b1, 1'b0);
    end
    s = cyc;
    for (int i = 0; i < WIN; i++) begin
      chk({tag, "_win_busy_m"},  busy_m, 1);
      chk({tag, "_win_busy_s"},  busy_s, 1);
      chk({tag, "_win_valid_m"}, valid_m, 0);
      ab = pat(mode, i);
      drive(ab[1], ab[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    exp_n = edges_from(s);
    chk_result(tag);
  endtask

  task automatic report(input int hold, input bit next_en, input int next_mode, input string tag);
    logic [1:0] ab;
    for (int h = 0; h < hold; h++) begin
      ab = pat(0, 0);
      drive(ab[1], ab[0], 1'($urandom_range(0, 1)), 1'b0);
      chk_result({tag, "_hold"});
    end
    ab = next_en ? pat(next_mode, -1) : pat(0, 0);
    drive(ab[1], ab[0], next_en, 1'b1);
    chk({tag, "_after_hs_valid"}, valid_m, 0);
    chk({tag, "_after_hs_busy"},  busy_m, next_en);
  endtask

  initial begin
    logic [1:0] ab;
    bit nxt;
    rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b0; out_ready = 1'b0;
    drive(0, 0, 1, 1);
    drive(1, 1, 1, 1);
    rst = 1'b0;
    chk("rst_busy_m",  busy_m, 0);
    chk("rst_valid_m", valid_m, 0);
    chk("rst_cnt_m",   cnt_m, 0);
    chk("rst_ovf_m",   ovf_m, 0);
    chk("rst_valid_s", valid_s, 0);
    for (int i = 0; i < 3; i++) begin
      ab = pat(0, 0);
      drive(ab[1], ab[0], 1'b0, 1'($urandom_range(0, 1)));
      chk("idle_busy", busy_m, 0);
    end

    // a=1, b period 4 starting low: four edges
    do_window(1, 1, "t1");
    chk("t1_cnt_const", cnt_m, 4);
    report(0, 0, 0, "t1");

    // a=0: no coincidence at all
    do_window(2, 1, "t2");
    chk("t2_cnt_const", cnt_m, 0);
    report(2, 0, 0, "t2");

    // back-pressure for 10 cycles, then back-to-back windows
    do_window(0, 1, "t3a");
    report(10, 1, 0, "t3a");
    do_window(0, 0, "t3b");
    report(0, 1, 3, "t3b");

    // w toggling every cycle: 8 edges overflow the 2-bit counter
    do_window(3, 0, "t4");
    chk("t4_cnt_m_const", cnt_m, 8);
`ifdef COINC_CNT_SATURATE_EN
    chk("t4_cnt_s_const", cnt_s, 3);
`else
    chk("t4_cnt_s_const", cnt_s, 0);
`endif
    chk("t4_ovf_s_const", ovf_s, 1);
    report(1, 0, 0, "t4");

    // steady w gives no edge; rise in the final cycle is counted
    drive(1, 1, 0, 0);
    do_window(4, 1, "t6a");
    chk("t6a_cnt_const", cnt_m, 0);
    report(0, 0, 0, "t6a");
    do_window(5, 1, "t6b");
    chk("t6b_cnt_const", cnt_m, 1);
    report(0, 0, 0, "t6b");

    // reset in the middle of a window discards everything
    ab = pat(0, -1);
    drive(ab[1], ab[0], 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ab = pat(3, i);
      drive(ab[1], ab[0], 1'b1, 1'b1);
    end
    chk("t5_pre_busy", busy_m, 1);
    rst = 1'b1;
    drive(1, 1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("t5_busy_m",  busy_m, 0);
    chk("t5_busy_s",  busy_s, 0);
    chk("t5_valid_m", valid_m, 0);
    chk("t5_cnt_m",   cnt_m, 0);
    chk("t5_cnt_s",   cnt_s, 0);
    chk("t5_ovf_s",   ovf_s, 0);
    for (int i = 0; i < 20; i++) begin
      ab = pat(0, 0);
      drive(ab[1], ab[0], 1'b0, 1'b1);
      chk("t5_no_valid", valid_m, 0);
    end

    // randomized windows, random back-pressure and chaining
    do_window(0, 1, "rnd");
    for (int r = 0; r < 8; r++) begin
      nxt = 1'($urandom_range(0, 1));
      report($urandom_range(0, 4), nxt, 0, "rnd");
      if (!nxt) begin
        ab = pat(0, 0);
        drive(ab[1], ab[0], 1'b0, 1'b0);
      end
      do_window(0, !nxt, "rnd");
    end
    report(0, 0, 0, "rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
